fdiv_pipe: RTL and testbench
============================

Name: fdiv_pipe

Overview:
- Pipelined single-precision divider, y = x1 / x2, computed as x1 × (1/x2).
- The significand reciprocal of x2 comes from the team's table-based Finv block (23-bit fraction in, 23-bit fraction out). fdiv_pipe instantiates Finv internally.
- fdiv_pipe is the consumer of that reciprocal path and sits in the FPU next to fmul and fadd.
- valid/ready handshake on both sides; fixed 3-cycle latency when the output is not stalled.

Parameters:
- None. Format is fixed to IEEE-754 binary32.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst  in  1  Reset. Synchronous, active-high.
- x1  in  32  Dividend, binary32.
- x2  in  32  Divisor, binary32.
- in_valid  in  1  x1/x2 valid.
- in_ready  out  1  Block accepts an operand pair this cycle.
- y  out  32  Quotient, binary32.
- out_valid  out  1  y valid.
- out_ready  in  1  Downstream accepts y.

Behaviour:
- Reset: all stage-valid bits clear. out_valid=0 and y=0 on the cycle after rst is high. in_ready=1 while rst is low and the pipe is empty.
- rst high mid-operation discards every in-flight pair. Nothing is emitted for them.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - A pair transfers when in_valid & in_ready.
  - Under stall all stages hold, and y/out_valid stay stable.
  - Otherwise every stage advances each cycle. Bubbles propagate; they are not collapsed.
- Latency: a pair accepted at edge N gives out_valid=1 after edge N+3 when there is no stall. Throughput is 1 pair per cycle.
- Stage 1 (unpack / reciprocal / special):
  - Split fields: s1,e1,m1 and s2,e2,m2.
  - Denormal inputs (e=0) are treated as signed zero.
  - r = Finv(m2).
  - If m2 == 0: force r = 0 and reciprocal exponent adjust ra = 0.
  - Otherwise: ra = 1, because 1/(1.m2) lies in (0.5,1) and is represented as 2^-1 × 1.r.
  - Register: sign s = s1^s2, {1,m1}, {1,r}, e1, e2, ra, special class.
- Stage 2 (multiply):
  - p = {1,m1} × {1,r}, 48-bit unsigned.
  - Biased exponent, 10-bit signed: ex = e1 − e2 + 127 − ra.
- Stage 3 (normalize / pack):
  - If p[47]=1: frac = p[46:24], ex = ex + 1.
  - Else: frac = p[45:23].
  - Rounding is truncation (toward zero).
  - ex ≥ 255 → ±inf.
  - ex ≤ 0 → ±0 (flush, no denormal output).
- Special cases, decided in stage 1 and carried through; they override arithmetic:
  - NaN in either operand, 0/0, or inf/inf → 0x7FC00000.
  - x/0 (x nonzero, finite) → s,0xFF,0 (signed inf).
  - inf/finite → signed inf.
  - 0/nonzero, and finite/inf → signed zero.
- Accuracy: for normal operands and normal results, |y − exact| ≤ 4 ulp. The m2==0 path is exact up to truncation.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0 and y=0 throughout, in_ready=1 after rst falls. Then a single pair x1=0x3F800000, x2=0x3F800000 → y=0x3F800000 (1.0/1.0) exactly 3 cycles after acceptance.
- Exact power-of-two divisor: 0x40C00000 / 0x40000000 (6/2) → 0x40400000. Then 0xC1200000 / 0x40800000 (−10/4) → 0xC0200000.
- Specials, back-to-back one per cycle:
  - 0x3F800000 / 0x00000000 → 0x7F800000
  - 0x00000000 / 0x00000000 → 0x7FC00000
  - 0x80000000 / 0x40000000 → 0x80000000
  - 0x3F800000 / 0x7F800000 → 0x00000000
  - 0x7F800000 / 0x7F800000 → 0x7FC00000
  - 0x00400000 (denormal) / 0x3F800000 → 0x00000000
- Range: 0x7F000000 / 0x3E800000 (2^127 / 0.25) → 0x7F800000. 0x00800000 / 0x40000000 (2^-126 / 2) → 0x00000000.
- Backpressure: stream 8 random normal pairs with out_ready toggling pseudo-randomly →
  - in_ready = ~(out_valid & ~out_ready) every cycle;
  - y stable while stalled;
  - all 8 results in order, each within 4 ulp of the reference model.
- Reset mid-flight: accept 3 pairs, assert rst for 1 cycle before any output → no out_valid for those pairs; the next accepted pair emits normally after 3 cycles.

Source files
------------

// File: rtl/fdiv_pipe.sv
// Pipelined binary32 divider y = x1 / x2 computed as x1 * (1/x2).
// Four register stages (unpack/recip, multiply, normalize, pack) with a global stall.
module finv (
    input  logic [22:0] frac_i,
    output logic [22:0] frac_o
);
    logic [23:0] div_d;
    logic [24:0] rem_d;
    logic [22:0] quo_d;

    // Fraction of 2/(1.frac); the integer bit is always 1 for a nonzero fraction.
    always_comb begin
        div_d = {1'b1, frac_i};
        rem_d = 25'h100_0000 - {1'b0, div_d};
        quo_d = '0;
        for (int i = 22; i >= 0; i--) begin
            rem_d = rem_d << 1;
            if (rem_d >= {1'b0, div_d}) begin
                rem_d    = rem_d - {1'b0, div_d};
                quo_d[i] = 1'b1;
            end
        end
        frac_o = quo_d;
    end
endmodule

module fdiv_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} sp_e;

    logic        stall;
    logic [22:0] r_w;

    logic        v1_q, v2_q, v3_q, v4_q;
    logic        s1_q, s2_q, s3_q;
    sp_e         sp1_q, sp2_q, sp3_q;
    logic [23:0] ma_q, mr_q;
    logic [7:0]  ea_q, eb_q;
    logic        ra_q;
    logic [47:0] p_q;
    logic signed [9:0] ex2_q, ex3_q;
    logic [22:0] frac3_q;
    logic [31:0] y_q;

    sp_e         sp1_d;
    logic [23:0] mr_d;
    logic        ra_d;
    logic [47:0] p_d;
    logic signed [9:0] ex2_d, ex3_d;
    logic [22:0] frac3_d;
    logic [31:0] y_d;

    assign stall     = v4_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v4_q;
    assign y         = y_q;

    finv u_finv (
        .frac_i (x2[22:0]),
        .frac_o (r_w)
    );

    always_comb begin
        logic z1, z2, f1, f2, nan1, nan2, inf1, inf2;
        z1   = (x1[30:23] == 8'h00);
        z2   = (x2[30:23] == 8'h00);
        f1   = (x1[30:23] == 8'hFF);
        f2   = (x2[30:23] == 8'hFF);
        nan1 = f1 & (x1[22:0] != 23'd0);
        nan2 = f2 & (x2[22:0] != 23'd0);
        inf1 = f1 & (x1[22:0] == 23'd0);
        inf2 = f2 & (x2[22:0] == 23'd0);
        sp1_d = SP_NONE;
        if (nan1 | nan2 | (z1 & z2) | (inf1 & inf2)) sp1_d = SP_NAN;
        else if (z2 | inf1)                          sp1_d = SP_INF;
        else if (z1 | inf2)                          sp1_d = SP_ZERO;
        // 1/1.0 is exactly 2^0, so it bypasses the 2^-1 * 1.r form.
        ra_d = (x2[22:0] != 23'd0);
        mr_d = ra_d ? {1'b1, r_w} : 24'h80_0000;
    end

    always_comb begin
        p_d   = {24'd0, ma_q} * {24'd0, mr_q};
        ex2_d = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127
                - $signed({9'd0, ra_q});
    end

    always_comb begin
        if (p_q[47]) begin
            frac3_d = p_q[46:24];
            ex3_d   = ex2_q + 10'sd1;
        end else begin
            frac3_d = p_q[45:23];
            ex3_d   = ex2_q;
        end
    end

    always_comb begin
        y_d = {s3_q, 31'd0};
        case (sp3_q)
            SP_NAN:  y_d = 32'h7FC0_0000;
            SP_INF:  y_d = {s3_q, 8'hFF, 23'd0};
            SP_ZERO: y_d = {s3_q, 31'd0};
            default: begin
                if (ex3_q >= 10'sd255)   y_d = {s3_q, 8'hFF, 23'd0};
                else if (ex3_q <= 10'sd0) y_d = {s3_q, 31'd0};
                else                      y_d = {s3_q, ex3_q[7:0], frac3_q};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            v4_q <= 1'b0;
            y_q  <= '0;
        end else if (!stall) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            if (v3_q) y_q <= y_d;
        end
    end

    // Datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_q    <= x1[31] ^ x2[31];
            sp1_q   <= sp1_d;
            ma_q    <= {1'b1, x1[22:0]};
            mr_q    <= mr_d;
            ea_q    <= x1[30:23];
            eb_q    <= x2[30:23];
            ra_q    <= ra_d;
            s2_q    <= s1_q;
            sp2_q   <= sp1_q;
            p_q     <= p_d;
            ex2_q   <= ex2_d;
            s3_q    <= s2_q;
            sp3_q   <= sp2_q;
            frac3_q <= frac3_d;
            ex3_q   <= ex3_d;
        end
    end
endmodule

// File: tb/tb_fdiv_pipe.sv
// Scoreboard bench for fdiv_pipe: directed vectors plus a truncated exact-division model.
module tb_fdiv_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x1, x2;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;

    typedef struct {
        logic [31:0] e;
        int          tol;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   bp_en  = 1'b0;

    fdiv_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .x1        (x1),
        .x2        (x2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, q;
        int              e;
        logic [22:0]     f;
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        q  = (ma << 25) / mb;
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q[25]) f = 23'(q >> 2);
        else begin
            f = 23'(q >> 1);
            e = e - 1;
        end
        return {a[31] ^ b[31], e[7:0], f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int tol, input bit push);
        int w;
        exp_t item;
        @(negedge clk);
        in_valid = 1'b1;
        x1 = a;
        x2 = b;
        #1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stuck low for %h/%h", a, b);
        end else if (push) begin
            item.e   = e;
            item.tol = tol;
            exp_q.push_back(item);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d results missing, expected 0", exp_q.size());
        end
    endtask

    task automatic timed_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        int lat;
        send(a, b, e, 0, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 10);
        check("latency", 32'(lat), 32'd3);
    endtask

    // Out_ready pattern: held at 1 outside the backpressure phase.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        bit          prev_stall = 1'b0;
        logic [31:0] prev_y = '0;
        exp_t        item;
        int          d;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en || rst) begin
                prev_stall = 1'b0;
                continue;
            end
            check("in_ready", {31'd0, in_ready}, {31'd0, ~(out_valid & ~out_ready)});
            if (prev_stall) begin
                check("stall_y", y, prev_y);
                check("stall_valid", {31'd0, out_valid}, 32'd1);
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got %h expected no output", y);
                end else begin
                    item = exp_q.pop_front();
                    d = int'(y[30:0]) - int'(item.e[30:0]);
                    if (d < 0) d = -d;
                    if (y[31] !== item.e[31] || d > item.tol) begin
                        n_err++;
                        $display("FAIL result: got %h expected %h (tol %0d ulp)", y, item.e, item.tol);
                    end
                end
            end
            prev_stall = out_valid & ~out_ready;
            prev_y     = y;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] sp_a [6] = '{32'h3F80_0000, 32'h0000_0000, 32'h8000_0000,
                              32'h3F80_0000, 32'h7F80_0000, 32'h0040_0000};
    logic [31:0] sp_b [6] = '{32'h0000_0000, 32'h0000_0000, 32'h4000_0000,
                              32'h7F80_0000, 32'h7F80_0000, 32'h3F80_0000};
    logic [31:0] sp_e [6] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h8000_0000,
                              32'h0000_0000, 32'h7FC0_0000, 32'h0000_0000};

    initial begin
        logic [31:0] a, b;
        rst      = 1'b1;
        in_valid = 1'b1;
        x1       = 32'h3F80_0000;
        x2       = 32'h3F80_0000;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_y", y, 32'd0);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        mon_en   = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        timed_pair(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        drain();

        send(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 1'b1);
        send(32'hC120_0000, 32'h4080_0000, 32'hC020_0000, 0, 1'b1);
        idle();
        drain();

        for (int i = 0; i < 6; i++) send(sp_a[i], sp_b[i], sp_e[i], 0, 1'b1);
        idle();
        drain();

        send(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 0, 1'b1);
        send(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 0, 1'b1);
        idle();
        drain();

        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 145)), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 145)), 23'($urandom)};
            send(a, b, ref_div(a, b), 4, 1'b1);
        end
        idle();
        drain();
        bp_en = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) send(32'h4000_0000, 32'h3F80_0000, 32'h0, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("flush_idle", {31'd0, out_valid}, 32'd0);
        timed_pair(32'h4040_0000, 32'h3F00_0000, 32'h40C0_0000);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
